// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer.
package stream_mux_pkg;

   localparam int unsigned MODE_SEL = 0;
   localparam int unsigned MODE_RR  = 1;

   // Ceiling log2, usable in constant expressions.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after last_grant wins.
module rr_arbiter
   import stream_mux_pkg::*;
#(
   parameter int unsigned NUM_IN = 4,
   localparam int unsigned SEL_W = clog2(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [SEL_W-1:0]  last_grant,
   output logic [SEL_W-1:0]  gnt,
   output logic              gnt_valid
);

   // Scan last_grant+1, last_grant+2, ... modulo NUM_IN; keep the first hit.
   always_comb begin
      gnt       = '0;
      gnt_valid = 1'b0;
      for (int unsigned k = 1; k <= NUM_IN; k++) begin
         if (!gnt_valid && req[SEL_W'((32'(last_grant) + k) % NUM_IN)]) begin
            gnt       = SEL_W'((32'(last_grant) + k) % NUM_IN);
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux_n.sv
// N:1 stream multiplexer with a one-deep registered output stage.
// Source is picked by an external select or by round-robin arbitration.
module stream_mux_n
   import stream_mux_pkg::*;
#(
   parameter int unsigned WIDTH  = 64,
   parameter int unsigned NUM_IN = 4,
   parameter int unsigned MODE   = MODE_SEL,
   localparam int unsigned SEL_W = clog2(NUM_IN)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic [NUM_IN-1:0]       in_valid,
   output logic [NUM_IN-1:0]       in_ready,
   input  logic [SEL_W-1:0]        sel,
   output logic [WIDTH-1:0]        out_data,
   output logic [SEL_W-1:0]        out_src,
   output logic                    out_valid,
   input  logic                    out_ready
);

   logic             load;
   logic             xfer;
   logic [SEL_W-1:0] gnt;
   logic             gnt_valid;
   logic [WIDTH-1:0] gnt_data;

   logic [WIDTH-1:0] out_data_q;
   logic [SEL_W-1:0] out_src_q;
   logic             out_valid_q;

   // Output register is free when empty or being drained this cycle.
   assign load = !out_valid_q | out_ready;
   assign xfer = load & gnt_valid;

   if (MODE == MODE_RR) begin : g_rr
      logic [SEL_W-1:0] last_grant_q;
      logic             unused_sel;

      assign unused_sel = ^sel;

      rr_arbiter #(
         .NUM_IN (NUM_IN)
      ) u_arb (
         .req        (in_valid),
         .last_grant (last_grant_q),
         .gnt        (gnt),
         .gnt_valid  (gnt_valid)
      );

      // Pointer advances only on an accepted input; starts so channel 0 goes first.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            last_grant_q <= SEL_W'(NUM_IN - 1);
         end else if (xfer) begin
            last_grant_q <= gnt;
         end
      end
   end else begin : g_sel
      // Out-of-range select matches no channel, so nothing is granted.
      always_comb begin
         gnt       = sel;
         gnt_valid = 1'b0;
         for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) gnt_valid = in_valid[i];
         end
      end
   end

   // Decode grant into one-hot ready and select the granted data word.
   always_comb begin
      in_ready = '0;
      gnt_data = '0;
      for (int unsigned i = 0; i < NUM_IN; i++) begin
         if (gnt == SEL_W'(i)) begin
            in_ready[i] = xfer;
            gnt_data    = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Output stage: load on transfer, clear valid on drain, hold on stall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_data_q  <= '0;
         out_src_q   <= '0;
         out_valid_q <= 1'b0;
      end else if (xfer) begin
         out_data_q  <= gnt_data;
         out_src_q   <= gnt;
         out_valid_q <= 1'b1;
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: one select-mode and one round-robin instance.
module tb_stream_mux_n;

   localparam int unsigned W = 64;
   localparam int unsigned N = 4;

   typedef struct packed {
      logic [W-1:0] data;
      logic [1:0]   src;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // Select-mode instance
   logic [N*W-1:0] s_in_data;
   logic [N-1:0]   s_in_valid, s_in_ready;
   logic [1:0]     s_sel, s_out_src;
   logic [W-1:0]   s_out_data;
   logic           s_out_valid, s_out_ready;

   // Round-robin instance
   logic [N*W-1:0] r_in_data;
   logic [N-1:0]   r_in_valid, r_in_ready;
   logic [1:0]     r_sel, r_out_src;
   logic [W-1:0]   r_out_data;
   logic           r_out_valid, r_out_ready;

   stream_mux_n #(.WIDTH(W), .NUM_IN(N), .MODE(0)) u_sel (
      .clk       (clk),
      .reset     (reset),
      .in_data   (s_in_data),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .sel       (s_sel),
      .out_data  (s_out_data),
      .out_src   (s_out_src),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready)
   );

   stream_mux_n #(.WIDTH(W), .NUM_IN(N), .MODE(1)) u_rr (
      .clk       (clk),
      .reset     (reset),
      .in_data   (r_in_data),
      .in_valid  (r_in_valid),
      .in_ready  (r_in_ready),
      .sel       (r_sel),
      .out_data  (r_out_data),
      .out_src   (r_out_src),
      .out_valid (r_out_valid),
      .out_ready (r_out_ready)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // Bench-side models
   exp_t         sq[$];
   exp_t         rq[$];
   logic         sm_valid;
   logic [W-1:0] sm_data;
   logic [1:0]   sm_src;
   logic         rm_valid;
   logic [W-1:0] rm_data;
   logic [1:0]   rm_src;
   int unsigned  rm_last;
   int           r_cnt [N];

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic models_reset();
      sq.delete();
      rq.delete();
      sm_valid = 1'b0; sm_data = '0; sm_src = '0;
      rm_valid = 1'b0; rm_data = '0; rm_src = '0;
      rm_last  = N - 1;
   endtask

   // One select-mode cycle: drive, check ready, clock, check output.
   task automatic sel_cycle(input string tag, input logic [1:0] s, input logic [N-1:0] v,
                            input logic ordy);
      logic       load, found;
      logic [N-1:0] er;
      exp_t e;
      s_sel = s; s_in_valid = v; s_out_ready = ordy;
      #1;
      load  = !sm_valid || ordy;
      found = v[s];
      er    = (load && found) ? (4'b0001 << s) : 4'b0000;
      chk({tag, " in_ready"}, W'(s_in_ready), W'(er));
      if (load && found) begin
         sm_data  = s_in_data[s*W +: W];
         sm_src   = s;
         sm_valid = 1'b1;
         sq.push_back('{data: sm_data, src: sm_src});
      end else if (ordy) begin
         sm_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk({tag, " out_valid"}, W'(s_out_valid), W'(sm_valid));
      if (load && found) begin
         e = sq.pop_front();
         chk({tag, " out_data"}, s_out_data, e.data);
         chk({tag, " out_src"}, W'(s_out_src), W'(e.src));
      end
   endtask

   // One round-robin cycle with fresh per-channel data each call.
   task automatic rr_cycle(input string tag, input logic [N-1:0] v, input logic ordy);
      logic        load, found;
      int unsigned win;
      logic [N-1:0] er;
      exp_t e;
      r_in_valid = v; r_out_ready = ordy;
      for (int c = 0; c < N; c++) r_in_data[c*W +: W] = {32'hC0DE_0000 | 32'(c), 32'(cyc)};
      cyc++;
      #1;
      load  = !rm_valid || ordy;
      found = 1'b0;
      win   = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         int unsigned c;
         c = (rm_last + k) % N;
         if (!found && v[c]) begin
            found = 1'b1;
            win   = c;
         end
      end
      er = (load && found) ? (4'b0001 << win) : 4'b0000;
      chk({tag, " in_ready"}, W'(r_in_ready), W'(er));
      for (int c = 0; c < N; c++) if (r_in_ready[c]) r_cnt[c]++;
      if (load && found) begin
         rm_last  = win;
         rm_data  = r_in_data[win*W +: W];
         rm_src   = 2'(win);
         rm_valid = 1'b1;
         rq.push_back('{data: rm_data, src: rm_src});
      end else if (ordy) begin
         rm_valid = 1'b0;
      end
      @(posedge clk); #1;
      chk({tag, " out_valid"}, W'(r_out_valid), W'(rm_valid));
      if (load && found) begin
         e = rq.pop_front();
         chk({tag, " out_data"}, r_out_data, e.data);
         chk({tag, " out_src"}, W'(r_out_src), W'(e.src));
      end else if (rm_valid) begin
         chk({tag, " held data"}, r_out_data, rm_data);
         chk({tag, " held src"}, W'(r_out_src), W'(rm_src));
      end
   endtask

   initial begin
      reset = 1'b1;
      s_in_data = '0; s_in_valid = '0; s_sel = '0; s_out_ready = 1'b0;
      r_in_data = '0; r_in_valid = '0; r_sel = '0; r_out_ready = 1'b0;
      for (int c = 0; c < N; c++) r_cnt[c] = 0;
      models_reset();

      // Reset state
      #3;
      chk("reset s_out_valid", W'(s_out_valid), '0);
      chk("reset s_out_data", s_out_data, '0);
      chk("reset r_out_valid", W'(r_out_valid), '0);
      chk("reset r_out_src", W'(r_out_src), '0);
      #19 reset = 1'b0;
      @(posedge clk); #1;

      // T2: select channel 2
      s_in_data[2*W +: W] = 64'hDEAD_BEEF_0000_0002;
      s_in_data[0*W +: W] = 64'h1111_0000_0000_0000;
      sel_cycle("T2", 2'd2, 4'b0100, 1'b1);
      chk("T2 const data", s_out_data, 64'hDEAD_BEEF_0000_0002);
      chk("T2 const src", W'(s_out_src), 64'd2);
      sel_cycle("T2 drain", 2'd2, 4'b0000, 1'b1);

      // T3: selected channel idle, no fallback to another
      sel_cycle("T3", 2'd3, 4'b0001, 1'b1);
      chk("T3 const valid", W'(s_out_valid), 64'd0);
      sel_cycle("T3b", 2'd0, 4'b0001, 1'b1);

      // T6: pointer starts at 3; skip and wrap
      rr_cycle("T6a", 4'b0010, 1'b1);
      chk("T6a src", W'(r_out_src), 64'd1);
      rr_cycle("T6b", 4'b1010, 1'b1);
      chk("T6b src", W'(r_out_src), 64'd3);
      rr_cycle("T6c", 4'b1010, 1'b1);
      chk("T6c src", W'(r_out_src), 64'd1);

      // T1: asynchronous reset while holding a word
      chk("T1 pre valid", W'(r_out_valid), 64'd1);
      r_in_valid = '0; s_in_valid = '0;
      #2 reset = 1'b1;
      #1;
      chk("T1 r_out_valid", W'(r_out_valid), '0);
      chk("T1 r_out_data", r_out_data, '0);
      chk("T1 r_out_src", W'(r_out_src), '0);
      models_reset();
      #3 reset = 1'b0;
      @(posedge clk); #1;

      // T4: all requesting, fair rotation from channel 0
      for (int c = 0; c < N; c++) r_cnt[c] = 0;
      for (int i = 0; i < 8; i++) begin
         rr_cycle("T4", 4'b1111, 1'b1);
         chk("T4 src seq", W'(r_out_src), W'(i % 4));
      end
      for (int c = 0; c < N; c++) chk("T4 pulses", W'(r_cnt[c]), 64'd2);

      // T5: backpressure holds everything, then resumes without a bubble
      rr_cycle("T5 load", 4'b1111, 1'b1);
      for (int i = 0; i < 5; i++) rr_cycle("T5 stall", (i % 2) ? 4'b1010 : 4'b0101, 1'b0);
      rr_cycle("T5 go1", 4'b1111, 1'b1);
      chk("T5 go1 src", W'(r_out_src), 64'd1);
      rr_cycle("T5 go2", 4'b1111, 1'b1);
      chk("T5 go2 src", W'(r_out_src), 64'd2);
      rr_cycle("T5 drain", 4'b0000, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
